// File: rtl/axis_stall_monitor_pkg.sv
// rtl/axis_stall_monitor_pkg.sv - shared FSM state encoding for the AXI-stream stall monitor
package axis_stall_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_WATCH   = 3'b010,
    ST_BLOCKED = 3'b100
  } mon_state_t;

  localparam int EVT_W = 8;

endpackage

// File: rtl/axis_port_stall_cnt.sv
// rtl/axis_port_stall_cnt.sv - per-port waiting detector with saturating stall counter and blocked flag
module axis_port_stall_cnt #(
  parameter bit IS_INPUT     = 1'b1,
  parameter int CNT_W        = 8,
  parameter int STALL_THRESH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic tvalid,
  input  logic tready,
  output logic waiting,
  output logic blocked
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  // An input port waits on data to arrive; an output port waits on the sink.
  assign waiting = IS_INPUT ? (tready && !tvalid) : (tvalid && !tready);

  always_comb begin
    count_next = '0;
    if (waiting) begin
      count_next = (&count) ? count : count + 1'b1;
    end
  end

  // Flag is loaded from the next count so it always equals (count >= threshold).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      blocked <= 1'b0;
    end else begin
      count   <= count_next;
      blocked <= (count_next >= CNT_W'(STALL_THRESH));
    end
  end

endmodule

// File: rtl/axis_stall_monitor.sv
// rtl/axis_stall_monitor.sv - kernel-level AXI-stream stall monitor (IDLE/WATCH/BLOCKED FSM)
// AXIS_STALL_MON_EVTCNT_EN enables the saturating block_events counter; otherwise it is tied to 0.
module axis_stall_monitor
  import axis_stall_monitor_pkg::*;
#(
  parameter int                   NUM_PORTS    = 2,
  parameter logic [NUM_PORTS-1:0] IN_MASK      = 2'b01,
  parameter int                   STALL_THRESH = 16,
  parameter int                   CNT_W        = 8,
  localparam int                  IDX_W        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 kernel_monitor_clock,
  input  logic                 kernel_monitor_reset,
  input  logic [NUM_PORTS-1:0] port_tvalid,
  input  logic [NUM_PORTS-1:0] port_tready,
  output logic [NUM_PORTS-1:0] axis_block_sigs,
  output logic                 block,
  output logic [IDX_W-1:0]     first_block_port,
  output logic [7:0]           block_events
);

  logic [NUM_PORTS-1:0] waiting;
  logic [NUM_PORTS-1:0] xfer;
  logic [NUM_PORTS-1:0] sigs;
  logic [CNT_W-1:0]     quiet;
  logic [IDX_W-1:0]     low_idx;
  logic                 any_wait;
  logic                 any_xfer;
  logic                 enter_blocked;
  mon_state_t           state;

  assign xfer     = port_tvalid & port_tready;
  assign any_wait = |waiting;
  assign any_xfer = |xfer;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    axis_port_stall_cnt #(
      .IS_INPUT     (IN_MASK[g]),
      .CNT_W        (CNT_W),
      .STALL_THRESH (STALL_THRESH)
    ) u_cnt (
      .clk     (kernel_monitor_clock),
      .rst     (kernel_monitor_reset),
      .tvalid  (port_tvalid[g]),
      .tready  (port_tready[g]),
      .waiting (waiting[g]),
      .blocked (sigs[g])
    );
  end

  assign axis_block_sigs = sigs;

  always_ff @(posedge kernel_monitor_clock or posedge kernel_monitor_reset) begin
    if (kernel_monitor_reset) begin
      quiet <= '0;
    end else if (any_xfer) begin
      quiet <= '0;
    end else if (!(&quiet)) begin
      quiet <= quiet + 1'b1;
    end
  end

  // Descending scan so the lowest set index wins.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (sigs[i]) begin
        low_idx = IDX_W'(i);
      end
    end
  end

  assign enter_blocked = (state == ST_WATCH) && (quiet >= CNT_W'(STALL_THRESH)) && (|sigs);

  always_ff @(posedge kernel_monitor_clock or posedge kernel_monitor_reset) begin
    if (kernel_monitor_reset) begin
      state            <= ST_IDLE;
      block            <= 1'b0;
      first_block_port <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_wait) begin
            state <= ST_WATCH;
          end
        end
        ST_WATCH: begin
          if (enter_blocked) begin
            state            <= ST_BLOCKED;
            block            <= 1'b1;
            first_block_port <= low_idx;
          end else if (!any_wait && !(|sigs)) begin
            state <= ST_IDLE;
          end
        end
        ST_BLOCKED: begin
          if (any_xfer) begin
            state <= ST_IDLE;
            block <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          block <= 1'b0;
        end
      endcase
    end
  end

`ifdef AXIS_STALL_MON_EVTCNT_EN
  logic [EVT_W-1:0] evt_cnt;

  always_ff @(posedge kernel_monitor_clock or posedge kernel_monitor_reset) begin
    if (kernel_monitor_reset) begin
      evt_cnt <= '0;
    end else if (enter_blocked && !(&evt_cnt)) begin
      evt_cnt <= evt_cnt + 1'b1;
    end
  end

  assign block_events = evt_cnt;
`else
  assign block_events = '0;
`endif

endmodule

// File: tb/tb_axis_stall_monitor.sv
// tb/tb_axis_stall_monitor.sv - randomized and directed bench for axis_stall_monitor against a behavioural model
module tb_axis_stall_monitor;

  localparam int         TH      = 16;
  localparam int         SAT     = 255;
  localparam logic [1:0] INM     = 2'b01;
  localparam int         M_IDLE  = 0;
  localparam int         M_WATCH = 1;
  localparam int         M_BLK   = 2;
`ifdef AXIS_STALL_MON_EVTCNT_EN
  localparam int         EVT_ON  = 1;
`else
  localparam int         EVT_ON  = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] tv  = 2'b00;
  logic [1:0] tr  = 2'b00;
  logic [1:0] sigs;
  logic       blk;
  logic [0:0] first;
  logic [7:0] evts;

  int vectors     = 0;
  int miscompares = 0;

  int m_run [2];
  int m_quiet;
  int m_state;
  int m_first;
  int m_evt;

  always #5 clk = ~clk;

  axis_stall_monitor #(
    .NUM_PORTS    (2),
    .IN_MASK      (INM),
    .STALL_THRESH (TH),
    .CNT_W        (8)
  ) dut (
    .kernel_monitor_clock (clk),
    .kernel_monitor_reset (rst),
    .port_tvalid          (tv),
    .port_tready          (tr),
    .axis_block_sigs      (sigs),
    .block                (blk),
    .first_block_port     (first),
    .block_events         (evts)
  );

  function automatic int sat_inc(input int x);
    return (x >= SAT) ? SAT : x + 1;
  endfunction

  // Packed expectation: {axis_block_sigs, block, first_block_port, block_events}
  function automatic logic [11:0] model_out();
    logic [1:0] s;
    for (int i = 0; i < 2; i++) s[i] = (m_run[i] >= TH);
    return {s, (m_state == M_BLK), 1'(m_first), (EVT_ON != 0) ? 8'(m_evt) : 8'd0};
  endfunction

  task automatic model_reset();
    m_run[0] = 0;
    m_run[1] = 0;
    m_quiet  = 0;
    m_state  = M_IDLE;
    m_first  = 0;
    m_evt    = 0;
  endtask

  task automatic model_step(input logic [1:0] v, input logic [1:0] r);
    bit wt [2];
    bit any_wait = 0;
    bit any_x    = 0;
    bit any_sig  = 0;
    int low      = -1;
    for (int i = 0; i < 2; i++) begin
      wt[i] = INM[i] ? (r[i] && !v[i]) : (v[i] && !r[i]);
      any_wait |= wt[i];
      any_x    |= (v[i] && r[i]);
      if (m_run[i] >= TH) begin
        any_sig = 1;
        if (low < 0) low = i;
      end
    end
    case (m_state)
      M_IDLE:  if (any_wait) m_state = M_WATCH;
      M_WATCH: begin
        if (m_quiet >= TH && any_sig) begin
          m_state = M_BLK;
          m_first = low;
          m_evt   = sat_inc(m_evt);
        end else if (!any_wait && !any_sig) begin
          m_state = M_IDLE;
        end
      end
      default: if (any_x) m_state = M_IDLE;
    endcase
    for (int i = 0; i < 2; i++) m_run[i] = wt[i] ? sat_inc(m_run[i]) : 0;
    m_quiet = any_x ? 0 : sat_inc(m_quiet);
  endtask

  task automatic cycle(input logic [1:0] v, input logic [1:0] r);
    tv = v;
    tr = r;
    @(posedge clk);
    model_step(v, r);
    #1;
  endtask

  task automatic do_reset();
    tv  = 2'b00;
    tr  = 2'b00;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({sigs, blk, first, evts} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_state: got %h want 000", {sigs, blk, first, evts});
    end
    cycle(2'b00, 2'b00);
    vectors++;
    if ({sigs, blk, first, evts} !== model_out()) begin
      miscompares++;
      $display("FAIL reset_idle: got %h want %h", {sigs, blk, first, evts}, model_out());
    end
  endtask

  task automatic test_input_stall();
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      cycle(2'b00, 2'b01);
      vectors++;
      if (sigs !== ((k >= TH) ? 2'b01 : 2'b00) || blk !== (k >= TH + 1)) begin
        miscompares++;
        $display("FAIL input_stall cyc %0d: got sigs=%b blk=%b want sigs=%b blk=%b",
                 k, sigs, blk, (k >= TH) ? 2'b01 : 2'b00, (k >= TH + 1));
      end
      vectors++;
      if ({sigs, blk, first, evts} !== model_out()) begin
        miscompares++;
        $display("FAIL input_stall_model cyc %0d: got %h want %h", k, {sigs, blk, first, evts}, model_out());
      end
    end
    vectors++;
    if (first !== 1'b0 || evts !== 8'(EVT_ON)) begin
      miscompares++;
      $display("FAIL input_stall_end: got first=%0d evt=%0d want first=0 evt=%0d", first, evts, EVT_ON);
    end
  endtask

  task automatic test_output_short();
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      cycle(2'b10, (k == 16) ? 2'b10 : 2'b00);
      vectors++;
      if (sigs !== 2'b00 || blk !== 1'b0) begin
        miscompares++;
        $display("FAIL output_short cyc %0d: got sigs=%b blk=%b want sigs=00 blk=0", k, sigs, blk);
      end
    end
    for (int k = 1; k <= 20; k++) cycle(2'b10, 2'b00);
    vectors++;
    if ({sigs, blk, first} !== 4'b1011 || {sigs, blk, first, evts} !== model_out()) begin
      miscompares++;
      $display("FAIL output_block: got %h want %h", {sigs, blk, first, evts}, model_out());
    end
  endtask

  task automatic test_both_stall();
    do_reset();
    for (int k = 1; k <= 20; k++) cycle(2'b10, 2'b01);
    vectors++;
    if ({sigs, blk, first} !== 4'b1110) begin
      miscompares++;
      $display("FAIL both_stall: got sigs=%b blk=%b first=%0d want sigs=11 blk=1 first=0", sigs, blk, first);
    end
    cycle(2'b11, 2'b01);
    vectors++;
    if (sigs !== 2'b10 || blk !== 1'b0 || {sigs, blk, first, evts} !== model_out()) begin
      miscompares++;
      $display("FAIL both_release: got %h want %h", {sigs, blk, first, evts}, model_out());
    end
    for (int k = 1; k <= 20; k++) begin
      cycle(2'b10, 2'b00);
      vectors++;
      if ({sigs, blk, first, evts} !== model_out()) begin
        miscompares++;
        $display("FAIL both_rewatch cyc %0d: got %h want %h", k, {sigs, blk, first, evts}, model_out());
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 1; k <= 300; k++) begin
      cycle(2'b00, 2'b01);
      if (k >= TH) begin
        vectors++;
        if (sigs[0] !== 1'b1 || (k > TH && blk !== 1'b1)) begin
          miscompares++;
          $display("FAIL saturation cyc %0d: got sigs=%b blk=%b want sigs[0]=1 blk=1", k, sigs, blk);
        end
      end
    end
  endtask

  task automatic test_event_count();
    do_reset();
    for (int e = 1; e <= 3; e++) begin
      for (int k = 1; k <= 20; k++) cycle(2'b00, 2'b01);
      cycle(2'b01, 2'b01);
      for (int k = 1; k <= 3; k++) cycle(2'b00, 2'b00);
      vectors++;
      if ({sigs, blk, first, evts} !== model_out()) begin
        miscompares++;
        $display("FAIL episode %0d: got %h want %h", e, {sigs, blk, first, evts}, model_out());
      end
    end
    vectors++;
    if (evts !== 8'(3 * EVT_ON)) begin
      miscompares++;
      $display("FAIL event_count: got %0d want %0d", evts, 3 * EVT_ON);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 1; k <= 20; k++) cycle(2'b00, 2'b01);
    vectors++;
    if (blk !== 1'b1) begin
      miscompares++;
      $display("FAIL async_pre: got blk=%b want 1", blk);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({sigs, blk, evts} !== 11'h000) begin
      miscompares++;
      $display("FAIL async_reset: got sigs=%b blk=%b evt=%0d want all 0", sigs, blk, evts);
    end
    tv = 2'b00;
    tr = 2'b00;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(2'b00, 2'b00);
    vectors++;
    if ({sigs, blk, first, evts} !== model_out()) begin
      miscompares++;
      $display("FAIL async_after: got %h want %h", {sigs, blk, first, evts}, model_out());
    end
  endtask

  task automatic test_random();
    logic [1:0] v;
    logic [1:0] r;
    int         len;
    int         n = 0;
    do_reset();
    while (n < 700) begin
      v   = 2'($urandom_range(0, 3));
      r   = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 24);
      for (int k = 0; k < len; k++) begin
        cycle(v, r);
        n++;
        vectors++;
        if ({sigs, blk, first, evts} !== model_out()) begin
          miscompares++;
          $display("FAIL random cyc %0d v=%b r=%b: got %h want %h", n, v, r, {sigs, blk, first, evts}, model_out());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_input_stall();
    test_output_short();
    test_both_stall();
    test_saturation();
    test_event_count();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
